// File: rtl/reg_file_if.sv
// Register file access bundle: read ports, writeback port and busy flag.
interface reg_file_if #(
  parameter int WIDTH = 48,
  parameter int AW    = 5
);
  logic             rd_en;
  logic [AW-1:0]    ra1;
  logic [AW-1:0]    ra2;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic             we;
  logic [AW-1:0]    wa;
  logic [WIDTH-1:0] wd;
  logic             busy;

  modport master (
    output rd_en, ra1, ra2, we, wa, wd,
    input  rd1, rd2, busy
  );

  modport slave (
    input  rd_en, ra1, ra2, we, wa, wd,
    output rd1, rd2, busy
  );
endinterface

// File: rtl/reg_file.sv
// Two-read/one-write register file with post-reset clear sweep.
// Define RF_BYPASS_EN for write-first reads on same-cycle collisions.
module reg_file #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic       clk,
  input  logic       rst,
  reg_file_if.slave  bus
);

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    clr_ptr_q, clr_ptr_d;
  logic [WIDTH-1:0] rd1_q, rd1_d;
  logic [WIDTH-1:0] rd2_q, rd2_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             mem_we;
  logic [AW-1:0]    mem_wa;
  logic [WIDTH-1:0] mem_wd;
  logic             ready;
  logic             wr_ok;
  logic             last_clr;
  logic             hit1, hit2;

  assign ready    = (state_q == READY);
  assign wr_ok    = ready && bus.we && (bus.wa != '0);
  assign last_clr = (clr_ptr_q == AW'(DEPTH - 1));

`ifdef RF_BYPASS_EN
  assign hit1 = wr_ok && (bus.ra1 == bus.wa);
  assign hit2 = wr_ok && (bus.ra2 == bus.wa);
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    mem_we    = 1'b0;
    mem_wa    = bus.wa;
    mem_wd    = bus.wd;
    unique case (state_q)
      CLEAR: begin
        mem_we = 1'b1;
        mem_wa = clr_ptr_q;
        mem_wd = '0;
        // Pointer parks at the last entry; only reset restarts the sweep
        if (last_clr) begin
          state_d = READY;
        end else begin
          clr_ptr_d = clr_ptr_q + AW'(1);
        end
      end
      READY: begin
        mem_we = wr_ok;
      end
    endcase
  end

  always_comb begin
    rd1_d = rd1_q;
    rd2_d = rd2_q;
    if (ready && bus.rd_en) begin
      if (bus.ra1 == '0) rd1_d = '0;
      else if (hit1)     rd1_d = bus.wd;
      else               rd1_d = mem_q[bus.ra1];
      if (bus.ra2 == '0) rd2_d = '0;
      else if (hit2)     rd2_d = bus.wd;
      else               rd2_d = mem_q[bus.ra2];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
      rd1_q     <= '0;
      rd2_q     <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      rd1_q     <= rd1_d;
      rd2_q     <= rd2_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem_q[mem_wa] <= mem_wd;
    end
  end

  assign bus.rd1  = rd1_q;
  assign bus.rd2  = rd2_q;
  assign bus.busy = (state_q == CLEAR);

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file against an array-based reference.
// Runs directed scenarios then a randomized read/write mix.
module tb_reg_file;

  localparam int W = 48;
  localparam int D = 32;
  localparam int A = 5;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  reg_file_if #(.WIDTH(W), .AW(A)) bus ();

  reg_file #(.WIDTH(W), .DEPTH(D), .AW(A)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [W-1:0] model [D];
  logic [W-1:0] exp1, exp2;
  int checks = 0;
  int passed = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.rd_en = 1'b0;
    bus.we    = 1'b0;
    bus.ra1   = '0;
    bus.ra2   = '0;
    bus.wa    = '0;
    bus.wd    = '0;
  endtask

  function automatic logic [W-1:0] ref_read(
    input logic [A-1:0] ra,
    input logic         we,
    input logic [A-1:0] wa,
    input logic [W-1:0] wd
  );
    if (ra == 0) return '0;
`ifdef RF_BYPASS_EN
    if (we && wa != 0 && wa == ra) return wd;
`endif
    return model[ra];
  endfunction

  // One READY-state cycle; updates expected outputs and model.
  task automatic do_op(
    input logic         we,
    input logic [A-1:0] wa,
    input logic [W-1:0] wd,
    input logic         rd_en,
    input logic [A-1:0] ra1,
    input logic [A-1:0] ra2
  );
    bus.we    = we;
    bus.wa    = wa;
    bus.wd    = wd;
    bus.rd_en = rd_en;
    bus.ra1   = ra1;
    bus.ra2   = ra2;
    tick();
    if (rd_en) begin
      exp1 = ref_read(ra1, we, wa, wd);
      exp2 = ref_read(ra2, we, wa, wd);
    end
    if (we && wa != 0) model[wa] = wd;
    idle();
  endtask

  // Pulse reset; the clear sweep zeroes the whole array.
  task automatic pulse_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < D; i++) model[i] = '0;
    exp1 = '0;
    exp2 = '0;
  endtask

  // Checks busy high and outputs zero for n cycles while poking inputs.
  task automatic busy_window(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      checks++;
      if (bus.busy !== 1'b1 || bus.rd1 !== '0 || bus.rd2 !== '0)
        $display("FAIL %s cyc%0d busy=%b rd1=%h rd2=%h want busy=1 rd=0",
                 tag, i, bus.busy, bus.rd1, bus.rd2);
      else passed++;
      bus.rd_en = 1'b1;
      bus.ra1   = A'($urandom_range(1, D - 1));
      bus.ra2   = A'($urandom_range(1, D - 1));
      tick();
    end
    idle();
    checks++;
    if (bus.busy !== 1'b0)
      $display("FAIL %s_end busy=%b want 0", tag, bus.busy);
    else passed++;
  endtask

  task automatic test_reset;
    bus.we    = 1'b1;
    bus.wa    = 5'd6;
    bus.wd    = 48'h1234_5678_9abc;
    bus.rd_en = 1'b1;
    pulse_reset();
    idle();
    busy_window(D, "reset_busy");
    for (int i = 0; i < D; i++) begin
      do_op(1'b0, '0, '0, 1'b1, A'(i), A'(D - 1 - i));
      checks++;
      if (bus.rd1 !== 48'h0 || bus.rd2 !== 48'h0)
        $display("FAIL reset_read a%0d rd1=%h rd2=%h want 0",
                 i, bus.rd1, bus.rd2);
      else passed++;
    end
  endtask

  task automatic test_write_read;
    do_op(1'b1, 5'd3, 48'h5555_5555_5555, 1'b0, '0, '0);
    do_op(1'b1, 5'd4, 48'hAAAA_AAAA_AAAA, 1'b0, '0, '0);
    do_op(1'b0, '0, '0, 1'b1, 5'd3, 5'd4);
    checks++;
    if (bus.rd1 !== 48'h5555_5555_5555 || bus.rd2 !== 48'hAAAA_AAAA_AAAA)
      $display("FAIL write_read rd1=%h rd2=%h want 555555555555 aaaaaaaaaaaa",
               bus.rd1, bus.rd2);
    else passed++;
    do_op(1'b0, '0, '0, 1'b1, 5'd4, 5'd4);
    checks++;
    if (bus.rd1 !== 48'hAAAA_AAAA_AAAA || bus.rd2 !== bus.rd1)
      $display("FAIL same_addr rd1=%h rd2=%h want aaaaaaaaaaaa both",
               bus.rd1, bus.rd2);
    else passed++;
  endtask

  task automatic test_r0_guard;
    do_op(1'b1, 5'd0, 48'hFFFF_FFFF_FFFF, 1'b0, '0, '0);
    do_op(1'b0, '0, '0, 1'b1, 5'd0, 5'd0);
    checks++;
    if (bus.rd1 !== 48'h0 || bus.rd2 !== 48'h0)
      $display("FAIL r0_guard rd1=%h rd2=%h want 0", bus.rd1, bus.rd2);
    else passed++;
    do_op(1'b1, 5'd0, 48'h1, 1'b1, 5'd0, 5'd3);
    checks++;
    if (bus.rd1 !== 48'h0 || bus.rd2 !== 48'h5555_5555_5555)
      $display("FAIL r0_collide rd1=%h rd2=%h want 0 555555555555",
               bus.rd1, bus.rd2);
    else passed++;
  endtask

  task automatic test_collision;
    logic [W-1:0] want;
`ifdef RF_BYPASS_EN
    want = 48'h10;
`else
    want = 48'h1;
`endif
    do_op(1'b1, 5'd7, 48'h1, 1'b0, '0, '0);
    do_op(1'b1, 5'd7, 48'h10, 1'b1, 5'd7, 5'd7);
    checks++;
    if (bus.rd1 !== want || bus.rd2 !== want)
      $display("FAIL collision rd1=%h rd2=%h want %h", bus.rd1, bus.rd2, want);
    else passed++;
    do_op(1'b0, '0, '0, 1'b1, 5'd7, 5'd0);
    checks++;
    if (bus.rd1 !== 48'h10)
      $display("FAIL collision_next rd1=%h want 000000000010", bus.rd1);
    else passed++;
  endtask

  task automatic test_hold;
    do_op(1'b0, '0, '0, 1'b1, 5'd3, 5'd4);
    do_op(1'b1, 5'd3, 48'h0bad_0bad_0bad, 1'b0, 5'd7, 5'd9);
    checks++;
    if (bus.rd1 !== 48'h5555_5555_5555 || bus.rd2 !== 48'hAAAA_AAAA_AAAA)
      $display("FAIL hold rd1=%h rd2=%h want 555555555555 aaaaaaaaaaaa",
               bus.rd1, bus.rd2);
    else passed++;
  endtask

  task automatic test_busy_write;
    pulse_reset();
    for (int i = 0; i < D; i++) begin
      bus.we = 1'b1;
      bus.wa = 5'd5;
      bus.wd = 48'h9;
      tick();
    end
    idle();
    checks++;
    if (bus.busy !== 1'b0)
      $display("FAIL busy_write_end busy=%b want 0", bus.busy);
    else passed++;
    do_op(1'b0, '0, '0, 1'b1, 5'd5, 5'd0);
    checks++;
    if (bus.rd1 !== 48'h0)
      $display("FAIL busy_write r5=%h want 000000000000", bus.rd1);
    else passed++;
  endtask

  task automatic test_mid_clear_reset;
    do_op(1'b1, 5'd9, 48'h2, 1'b0, '0, '0);
    do_op(1'b0, '0, '0, 1'b1, 5'd9, 5'd0);
    checks++;
    if (bus.rd1 !== 48'h2)
      $display("FAIL mid_pre r9=%h want 000000000002", bus.rd1);
    else passed++;
    pulse_reset();
    for (int i = 0; i < 10; i++) tick();
    pulse_reset();
    busy_window(D, "mid_busy");
    do_op(1'b0, '0, '0, 1'b1, 5'd9, 5'd9);
    checks++;
    if (bus.rd1 !== 48'h0 || bus.rd2 !== 48'h0)
      $display("FAIL mid_clear r9=%h/%h want 0", bus.rd1, bus.rd2);
    else passed++;
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      do_op(1'($urandom_range(0, 1)), A'($urandom_range(0, D - 1)),
            W'({$urandom(), $urandom()}), 1'($urandom_range(0, 3) != 0),
            A'($urandom_range(0, D - 1)), A'($urandom_range(0, D - 1)));
      checks++;
      if (bus.rd1 !== exp1 || bus.rd2 !== exp2)
        $display("FAIL random op%0d rd1=%h rd2=%h want %h %h",
                 i, bus.rd1, bus.rd2, exp1, exp2);
      else passed++;
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 1; i < 8; i++) begin
      do_op(1'b1, A'(i), W'(i * 48'h1111), 1'b1, A'(i - 1), A'(i));
      checks++;
      if (bus.rd1 !== exp1 || bus.rd2 !== exp2)
        $display("FAIL b2b a%0d rd1=%h rd2=%h want %h %h",
                 i, bus.rd1, bus.rd2, exp1, exp2);
      else passed++;
    end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    test_reset();
    test_write_read();
    test_r0_guard();
    test_collision();
    test_hold();
    test_back_to_back();
    test_busy_write();
    test_mid_clear_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter: WIDTH, 48, data word width; matches the ALU operand width.
REQ-002 Parameter: DEPTH, 32, number of registers.
REQ-003 Parameter: AW, 5, address width (log2 DEPTH).
REQ-004 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-005 Port: rst  input  1  synchronous, active-high reset.
REQ-006 Port: rd_en  input  1  read enable for both read ports.
REQ-007 Port: ra1  input  AW  read address, port 1 (feeds ALU operand a).
REQ-008 Port: ra2  input  AW  read address, port 2 (feeds ALU operand b).
REQ-009 Port: rd1  output  WIDTH  registered read data, port 1.
REQ-010 Port: rd2  output  WIDTH  registered read data, port 2.
REQ-011 Port: we  input  1  write enable (ALU result writeback).
REQ-012 Port: wa  input  AW  write address.
REQ-013 Port: wd  input  WIDTH  write data.
REQ-014 Port: busy  output  1  high while the post-reset clear sequence runs.

Function
REQ-015 The block SHALL implement two states: CLEAR and READY.
REQ-016 In CLEAR, the block SHALL write 0 to entry clr_ptr every cycle and increment clr_ptr.
REQ-017 CLEAR SHALL transition to READY in the cycle after entry DEPTH-1 is cleared; busy SHALL fall with that transition (busy high for exactly DEPTH cycles after rst deasserts).
REQ-018 While busy=1, the block SHALL ignore we and rd_en, and rd1/rd2 SHALL hold 0.
REQ-019 In READY, a rising edge with we=1 and wa!=0 SHALL store wd into entry wa.
REQ-020 Writes to address 0 SHALL be discarded; entry 0 SHALL always read as 0.
REQ-021 In READY with rd_en=1, rd1/rd2 SHALL load mem[ra1]/mem[ra2] at the rising edge (1-cycle latency).
REQ-022 With rd_en=0, rd1/rd2 SHALL hold their previous values.
REQ-023 ra1==ra2 SHALL return identical data on both ports.
REQ-024 If a read and a write target the same nonzero address in the same cycle, the read result SHALL follow REQ-031/REQ-032.
REQ-025 clr_ptr SHALL be AW bits wide and SHALL NOT wrap back into CLEAR after reaching DEPTH-1.

Reset
REQ-026 rst=1 at a rising edge SHALL set rd1=0, rd2=0, busy=1, clr_ptr=0, and state=CLEAR.
REQ-027 Reset SHALL take priority over all other inputs.
REQ-028 Reset asserted during CLEAR SHALL restart clearing from entry 0.
REQ-029 Reset asserted during READY SHALL discard any same-cycle write.
REQ-030 busy SHALL read 1 in the first cycle after rst deasserts.

Configuration
REQ-031 With macro RF_BYPASS_EN defined, a same-cycle read of the address being written (nonzero) SHALL return wd (write-first).
REQ-032 Without RF_BYPASS_EN, that read SHALL return the pre-write contents (read-first); the new value SHALL be visible on the next read.

Verification
REQ-033 Reset: pulse rst for 1 cycle -> busy=1 for 32 cycles then 0; rd1=rd2=0 throughout; rd_en reads of every address after busy falls return 000000000000.
REQ-034 Write/read: write 5555_5555_5555 to r3 and AAAA_AAAA_AAAA to r4; read ra1=3, ra2=4 -> next cycle rd1=555555555555, rd2=aaaaaaaaaaaa.
REQ-035 r0 guard: write FFFF_FFFF_FFFF to r0; read ra1=0 -> rd1=000000000000.
REQ-036 Collision: r7 holds 000000000001; write 000000000010 to r7 while reading ra1=7 -> rd1=000000000010 with RF_BYPASS_EN, 000000000001 without; next read returns 000000000010 in both builds.
REQ-037 Hold/busy: with rd_en=0, change ra1 -> rd1 unchanged; assert we during busy to r5=0000_0000_0009 -> r5 reads 000000000000 after busy falls.
REQ-038 Mid-clear reset: after r9=0000_0000_0002 is written, assert rst, then reassert it 10 cycles into CLEAR -> busy stays high 32 cycles after the final deassert; r9 reads 000000000000.
